// File: rtl/vector_addsub_pipe.sv
// rtl/vector_addsub_pipe.sv - two-stage per-component signed vector add/subtract with saturation
module vector_addsub_pipe #(
  parameter int COMP_WIDTH = 19,
  parameter int NUM_COMP   = 3,
  parameter int SATURATE   = 1
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           in_valid,
  output logic                           in_ready,
  input  logic                           in_op,
  input  logic [NUM_COMP*COMP_WIDTH-1:0] in_vector_1,
  input  logic [NUM_COMP*COMP_WIDTH-1:0] in_vector_2,
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic [NUM_COMP*COMP_WIDTH-1:0] out_vector,
  output logic [NUM_COMP-1:0]            out_ovf
);

  localparam int W  = COMP_WIDTH;
  localparam int RW = COMP_WIDTH + 1;
  localparam int VW = NUM_COMP * COMP_WIDTH;
  localparam logic [W-1:0] MAX_POS = {1'b0, {(W-1){1'b1}}};
  localparam logic [W-1:0] MIN_NEG = {1'b1, {(W-1){1'b0}}};

  logic                         s1_valid, s2_valid;
  logic                         s1_adv, s2_adv;
  logic [NUM_COMP-1:0][RW-1:0]  s1_raw, raw_next;
  logic [RW-1:0]                a_ext, b_ext;
  logic [RW-1:0]                r;
  logic [W-1:0]                 res;
  logic [VW-1:0]                res_next, res_q;
  logic [NUM_COMP-1:0]          ovf_next, ovf_q;

  assign s2_adv     = !s2_valid || out_ready;
  assign s1_adv     = !s1_valid || s2_adv;
  assign in_ready   = s1_adv;
  assign out_valid  = s2_valid;
  assign out_vector = res_q;
  assign out_ovf    = ovf_q;

  // Component i is x for i=0 and lives at the MSB end of the packed vector.
  always_comb begin
    raw_next = '0;
    a_ext    = '0;
    b_ext    = '0;
    for (int i = 0; i < NUM_COMP; i++) begin
      a_ext = {in_vector_1[(NUM_COMP-1-i)*W + W-1], in_vector_1[(NUM_COMP-1-i)*W +: W]};
      b_ext = {in_vector_2[(NUM_COMP-1-i)*W + W-1], in_vector_2[(NUM_COMP-1-i)*W +: W]};
      raw_next[i] = a_ext + (in_op ? ~b_ext : b_ext) + RW'(in_op);
    end
  end

  // Overflow shows up as disagreement between the extra sign bit and the result sign bit.
  always_comb begin
    res_next = '0;
    ovf_next = '0;
    r        = '0;
    res      = '0;
    for (int i = 0; i < NUM_COMP; i++) begin
      r   = s1_raw[i];
      res = r[W-1:0];
      if ((SATURATE != 0) && (r[W] != r[W-1]))
        res = r[W] ? MIN_NEG : MAX_POS;
      res_next[(NUM_COMP-1-i)*W +: W] = res;
      ovf_next[NUM_COMP-1-i]          = r[W] ^ r[W-1];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_raw   <= '0;
      s2_valid <= 1'b0;
      res_q    <= '0;
      ovf_q    <= '0;
    end else begin
      if (s1_adv) begin
        s1_valid <= in_valid;
        if (in_valid)
          s1_raw <= raw_next;
      end
      if (s2_adv) begin
        s2_valid <= s1_valid;
        if (s1_valid) begin
          res_q <= res_next;
          ovf_q <= ovf_next;
        end
      end
    end
  end

endmodule

// File: doc/vector_addsub_pipe.md
VECTOR_ADDSUB_PIPE -- requirements
Module: vector_addsub_pipe

Interface
REQ-001 SHALL have parameter COMP_WIDTH, default 19, meaning bits per signed fixed-point component (Q9.10 at default).
REQ-002 SHALL have parameter NUM_COMP, default 3, meaning components per vector (x, y, z at default).
REQ-003 SHALL have parameter SATURATE, default 1, meaning 1 = clamp on overflow and 0 = two's-complement wrap.
REQ-004 SHALL define VW = NUM_COMP*COMP_WIDTH (57 at defaults) as the vector width used by the ports below.
REQ-005 SHALL have port clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-006 SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-007 SHALL have port in_valid, input, 1 bit: input operands valid.
REQ-008 SHALL have port in_ready, output, 1 bit: block accepts input this cycle.
REQ-009 SHALL have port in_op, input, 1 bit: 0 = add (v1+v2), 1 = subtract (v1-v2).
REQ-010 SHALL have ports in_vector_1 and in_vector_2, input, VW bits: packed operands, component 0 (x) at the MSBs, i.e. {x,y,z}.
REQ-011 SHALL have port out_valid, output, 1 bit: result valid.
REQ-012 SHALL have port out_ready, input, 1 bit: downstream accepts result.
REQ-013 SHALL have port out_vector, output, VW bits: result, packed in the same order as the inputs.
REQ-014 SHALL have port out_ovf, output, NUM_COMP bits: per-component overflow flag, bit NUM_COMP-1 = component 0 (x).

Function
REQ-015 SHALL transfer on the input when in_valid && in_ready, and on the output when out_valid && out_ready.
REQ-016 SHALL be a two-stage pipeline. S1 registers the raw (COMP_WIDTH+1)-bit sign-extended sum or difference per component plus a valid bit. S2 registers the final result, flags and valid.
REQ-017 SHALL have a latency of exactly 2 cycles from input transfer to out_valid when out_ready stays high, and SHALL sustain 1 transfer per cycle.
REQ-018 SHALL advance S2 when !s2_valid || out_ready.
REQ-019 SHALL advance S1 when !s1_valid || S2 advances.
REQ-020 SHALL drive in_ready = !s1_valid || S2 advances; in_ready SHALL NOT depend combinationally on in_valid.
REQ-021 SHALL hold out_vector, out_ovf and out_valid stable while out_valid && !out_ready, with no data loss or duplication.
REQ-022 SHALL compute subtraction as v1 + ~v2 + 1 at COMP_WIDTH+1 bits; each component SHALL be independent, with no carry between components.
REQ-023 SHALL set out_ovf[i] when the COMP_WIDTH+1-bit raw result is outside [-2^(COMP_WIDTH-1), 2^(COMP_WIDTH-1)-1].
REQ-024 SHALL, when SATURATE=1 and overflow occurs, output 2^(COMP_WIDTH-1)-1 on a positive overflow and -2^(COMP_WIDTH-1) on a negative overflow.
REQ-025 SHALL, when SATURATE=0, output the low COMP_WIDTH bits of the raw result; out_ovf SHALL still be reported.
REQ-026 SHALL handle an input transfer and an output transfer in the same cycle with both pipeline stages full without a bubble.
REQ-027 SHALL apply in_op per transaction, captured with the operands, so mixed add/sub streams are correct.

Reset
REQ-028 SHALL, while rst is high, clear s1_valid, s2_valid, out_valid and out_ovf to 0 and out_vector to 0, and drive in_ready to 1, independent of clk.
REQ-029 SHALL, on rst assertion mid-operation, discard all in-flight transactions.
REQ-030 SHALL produce the first valid output no earlier than 2 cycles after the first post-reset input transfer.

Verification
REQ-031 SHALL be verified for basic add at defaults: x=0x00600 (1.5) + 0x00900 (2.25) -> 0x00F00 (3.75) after 2 cycles, ovf=000.
REQ-032 SHALL be verified for saturate add: x=0x3FFFF + 0x00001, SATURATE=1 -> x=0x3FFFF, out_ovf=100; with SATURATE=0 -> x=0x40000, out_ovf=100.
REQ-033 SHALL be verified for saturate subtract: z=0x40000 - 0x00001, in_op=1 -> z=0x40000, out_ovf=001; y=0x00000 - 0x40000 -> y=0x3FFFF, out_ovf=010.
REQ-034 SHALL be verified for backpressure: stream 8 back-to-back vectors with out_ready low for cycles 3-6 -> in_ready low after both stages fill, all 8 results delivered in order, none duplicated.
REQ-035 SHALL be verified for mid-stream reset: rst pulsed while both stages are valid -> out_valid=0 immediately, in_ready=1, and the next input emerges 2 cycles after acceptance.
REQ-036 SHALL be verified for parameter sweep: COMP_WIDTH=8, NUM_COMP=4 -> random add/sub results match a reference model on every component, including carry isolation at component boundaries.
